// File: rtl/shift_sequencer_pkg.sv
// Shared types and constants for the multi-pass shift sequencer and its barrel shifter.
// Command amounts exceed one shifter pass, so the step helper clamps each pass to MAX_STEP.
package shift_pkg;

  localparam int DATA_W   = 32;
  localparam int AMT_W    = 6;
  localparam int STEP_W   = 5;
  localparam int MAX_STEP = DATA_W - 1;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  // Largest amount the shifter can take this pass; truncation only happens when rem fits.
  function automatic logic [STEP_W-1:0] step_of(input logic [AMT_W-1:0] rem);
    if (rem > AMT_W'(MAX_STEP)) begin
      return STEP_W'(MAX_STEP);
    end
    return rem[STEP_W-1:0];
  endfunction

endpackage

// File: rtl/shift_sequencer_if.sv
// Command and result handshakes between ALU issue, the shift sequencer and writeback.
// The sequencer uses the slave modport; the issuing/consuming side uses master.
interface shift_sequencer_if;
  import shift_pkg::*;

  logic                IN_VALID;
  logic                IN_READY;
  logic                IN_DIR;
  logic [AMT_W-1:0]    IN_AMT;
  logic [DATA_W-1:0]   IN_DATA;
  logic                OUT_VALID;
  logic                OUT_READY;
  logic [DATA_W-1:0]   OUT_DATA;

  modport slave (
    input  IN_VALID, IN_DIR, IN_AMT, IN_DATA, OUT_READY,
    output IN_READY, OUT_VALID, OUT_DATA
  );

  modport master (
    output IN_VALID, IN_DIR, IN_AMT, IN_DATA, OUT_READY,
    input  IN_READY, OUT_VALID, OUT_DATA
  );

endinterface

// File: rtl/shift_sequencer_barrel_shifter.sv
// Combinational 32-bit shifter: SH_DIR=1 arithmetic right, SH_DIR=0 logical left, 0..31 bits.
// Zero latency; no handshake.
module Barrel_Shifter
  import shift_pkg::*;
(
  input  logic              SH_DIR,
  input  logic [STEP_W-1:0] SH_AMT,
  input  logic [DATA_W-1:0] SH_IN,
  output logic [DATA_W-1:0] SH_OUT
);

  always_comb begin
    SH_OUT = SH_IN;
    if (SH_DIR == DIR_RIGHT) begin
      SH_OUT = $signed(SH_IN) >>> SH_AMT;
    end else begin
      SH_OUT = SH_IN << SH_AMT;
    end
  end

endmodule

// File: rtl/shift_sequencer.sv
// Extends the 32-bit barrel shifter to 0..63-bit amounts by 1-3 passes; result after N edges.
// One command in flight; IN_READY only in IDLE, result held in DONE until OUT_READY.
module shift_sequencer
  import shift_pkg::*;
(
  input  logic             CLK,
  input  logic             RST_N,
  shift_sequencer_if.slave sif,
  output logic             BUSY
);

  state_e             state_q, state_d;
  logic               dir_q,   dir_d;
  logic [DATA_W-1:0]  acc_q,   acc_d;
  logic [AMT_W-1:0]   rem_q,   rem_d;
  logic [STEP_W-1:0]  step;
  logic [DATA_W-1:0]  shifted;

  assign step = step_of(rem_q);

  Barrel_Shifter u_barrel (
    .SH_DIR (dir_q),
    .SH_AMT (step),
    .SH_IN  (acc_q),
    .SH_OUT (shifted)
  );

  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    acc_d   = acc_q;
    rem_d   = rem_q;
    case (state_q)
      IDLE: begin
        if (sif.IN_VALID) begin
          dir_d   = sif.IN_DIR;
          acc_d   = sif.IN_DATA;
          rem_d   = sif.IN_AMT;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        // step never exceeds rem, so the subtraction cannot wrap.
        acc_d = shifted;
        rem_d = rem_q - AMT_W'(step);
        if (rem_q <= AMT_W'(MAX_STEP)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (sif.OUT_READY) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      dir_q   <= 1'b0;
      acc_q   <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      acc_q   <= acc_d;
      rem_q   <= rem_d;
    end
  end

  // Ready is withheld while reset is asserted so nothing is offered to a held block.
  assign sif.IN_READY  = (state_q == IDLE) && RST_N;
  assign sif.OUT_VALID = (state_q == DONE);
  assign sif.OUT_DATA  = acc_q;
  assign BUSY          = (state_q != IDLE);

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed bench for shift_sequencer: hand-computed vectors, full amount sweep, backpressure, reset abort.
module tb_shift_sequencer;
  import shift_pkg::*;

  logic clk;
  logic rst_n;
  logic busy;
  int   n_cmp;
  int   n_err;

  shift_sequencer_if sif ();

  shift_sequencer dut (
    .CLK   (clk),
    .RST_N (rst_n),
    .sif   (sif),
    .BUSY  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_shift(input logic dir, input logic [5:0] amt, input logic [31:0] d);
    if (dir) return $signed(d) >>> amt;
    return d << amt;
  endfunction

  function automatic int ref_passes(input logic [5:0] amt);
    if (amt <= 6'd31) return 1;
    if (amt <= 6'd62) return 2;
    return 3;
  endfunction

  // Issue one command from IDLE, measure latency, check result, then drain it.
  task automatic run_cmd(input string tag, input logic dir, input logic [5:0] amt,
                         input logic [31:0] d, input logic [31:0] exp, input int exp_lat);
    int lat;
    check_eq({tag, "_in_ready"}, {31'd0, sif.IN_READY}, 32'd1);
    sif.IN_VALID = 1'b1;
    sif.IN_DIR   = dir;
    sif.IN_AMT   = amt;
    sif.IN_DATA  = d;
    @(posedge clk); #1;
    sif.IN_VALID = 1'b0;
    lat = 0;
    while (!sif.OUT_VALID && lat < 8) begin
      check_eq({tag, "_busy_shift"}, {31'd0, busy}, 32'd1);
      @(posedge clk); #1;
      lat++;
    end
    check_eq({tag, "_latency"}, lat, exp_lat);
    check_eq({tag, "_data"}, sif.OUT_DATA, exp);
    check_eq({tag, "_busy_done"}, {31'd0, busy}, 32'd1);
    sif.OUT_READY = 1'b1;
    @(posedge clk); #1;
    sif.OUT_READY = 1'b0;
    check_eq({tag, "_ret_ready"}, {31'd0, sif.IN_READY}, 32'd1);
    check_eq({tag, "_ret_valid"}, {31'd0, sif.OUT_VALID}, 32'd0);
    check_eq({tag, "_ret_busy"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] sweep_d [2];
    n_cmp = 0;
    n_err = 0;
    rst_n         = 1'b0;
    sif.IN_VALID  = 1'b0;
    sif.IN_DIR    = 1'b0;
    sif.IN_AMT    = '0;
    sif.IN_DATA   = '0;
    sif.OUT_READY = 1'b0;
    sweep_d[0] = 32'h8765_4321;
    sweep_d[1] = 32'h3C5A_0F96;

    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_out_valid", {31'd0, sif.OUT_VALID}, 32'd0);
    check_eq("rst_out_data", sif.OUT_DATA, 32'd0);
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_eq("rst_rel_ready", {31'd0, sif.IN_READY}, 32'd1);
    @(posedge clk); #1;

    run_cmd("r4_msb",   1'b1, 6'd4,  32'h8000_0000, 32'hF800_0000, 1);
    run_cmd("r4_b30",   1'b1, 6'd4,  32'h4000_0000, 32'h0400_0000, 1);
    run_cmd("l31",      1'b0, 6'd31, 32'h0000_0001, 32'h8000_0000, 1);
    run_cmd("l40",      1'b0, 6'd40, 32'h0000_0001, 32'h0000_0000, 2);
    run_cmd("r63_msb",  1'b1, 6'd63, 32'h8000_0000, 32'hFFFF_FFFF, 3);
    run_cmd("r63_b30",  1'b1, 6'd63, 32'h4000_0000, 32'h0000_0000, 3);
    run_cmd("r0",       1'b1, 6'd0,  32'hDEAD_BEEF, 32'hDEAD_BEEF, 1);
    run_cmd("l0",       1'b0, 6'd0,  32'hDEAD_BEEF, 32'hDEAD_BEEF, 1);
    run_cmd("r32",      1'b1, 6'd32, 32'h9000_0001, 32'hFFFF_FFFF, 2);
    run_cmd("l62",      1'b0, 6'd62, 32'hFFFF_FFFF, 32'h0000_0000, 2);
    run_cmd("r36",      1'b1, 6'd36, 32'h7FFF_FFFF, 32'h0000_0000, 2);

    for (int dir_i = 0; dir_i < 2; dir_i++) begin
      for (int a = 0; a < 64; a++) begin
        run_cmd($sformatf("sweep_d%0d_a%0d", dir_i, a), dir_i[0], a[5:0], sweep_d[dir_i],
                ref_shift(dir_i[0], a[5:0], sweep_d[dir_i]), ref_passes(a[5:0]));
      end
    end

    // Backpressure: result held while OUT_READY is low, new command refused.
    sif.IN_VALID = 1'b1;
    sif.IN_DIR   = 1'b1;
    sif.IN_AMT   = 6'd4;
    sif.IN_DATA  = 32'h8000_0000;
    @(posedge clk); #1;
    sif.IN_DATA  = 32'h1234_5678;
    sif.IN_AMT   = 6'd1;
    sif.IN_DIR   = 1'b0;
    @(posedge clk); #1;
    for (int c = 0; c < 5; c++) begin
      check_eq($sformatf("bp_valid_%0d", c), {31'd0, sif.OUT_VALID}, 32'd1);
      check_eq($sformatf("bp_data_%0d", c), sif.OUT_DATA, 32'hF800_0000);
      check_eq($sformatf("bp_ready_%0d", c), {31'd0, sif.IN_READY}, 32'd0);
      @(posedge clk); #1;
    end
    sif.IN_VALID  = 1'b0;
    sif.OUT_READY = 1'b1;
    @(posedge clk); #1;
    sif.OUT_READY = 1'b0;
    check_eq("bp_rel_ready", {31'd0, sif.IN_READY}, 32'd1);
    check_eq("bp_rel_valid", {31'd0, sif.OUT_VALID}, 32'd0);
    check_eq("bp_rel_data", sif.OUT_DATA, 32'hF800_0000);
    @(posedge clk); #1;
    check_eq("bp_idle_stays", {31'd0, busy}, 32'd0);

    // Reset during the second pass of a 50-bit shift.
    sif.IN_VALID = 1'b1;
    sif.IN_DIR   = 1'b0;
    sif.IN_AMT   = 6'd50;
    sif.IN_DATA  = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    sif.IN_VALID = 1'b0;
    @(posedge clk); #1;
    check_eq("mid_busy", {31'd0, busy}, 32'd1);
    check_eq("mid_acc_pass1", sif.OUT_DATA, 32'h8000_0000);
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_valid", {31'd0, sif.OUT_VALID}, 32'd0);
    check_eq("mid_rst_data", sif.OUT_DATA, 32'd0);
    check_eq("mid_rst_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_eq("mid_rel_ready", {31'd0, sif.IN_READY}, 32'd1);
    repeat (3) begin
      @(posedge clk); #1;
      check_eq("mid_no_valid", {31'd0, sif.OUT_VALID}, 32'd0);
    end
    run_cmd("post_rst", 1'b1, 6'd8, 32'hF000_000F, 32'hFFF0_0000, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/shift_sequencer.md
Name: shift_sequencer

Overview:
Sequential front-end that owns the combinational Barrel_Shifter and extends it to 6-bit shift amounts (0..63) through repeated passes.
- Accepts one shift command per transaction over a valid/ready handshake.
- Iterates the 32-bit shifter in steps of at most 31.
- Presents the registered result downstream over a second valid/ready handshake.
- Sits between the ALU issue logic (upstream) and the writeback stage (downstream).

Parameters:
DATA_W, 32, datapath width; must match Barrel_Shifter.
AMT_W, 6, command shift-amount width; covers amounts 0..2*DATA_W-1.
MAX_STEP, DATA_W-1 (31), largest single-pass amount the shifter accepts.

Ports:
CLK  in  1  single clock, rising edge.
RST_N  in  1  asynchronous reset, active-low.
IN_VALID  in  1  command valid.
IN_READY  out  1  sequencer can accept a command.
IN_DIR  in  1  1 = arithmetic shift-right, 0 = logical shift-left; same encoding as SH_DIR.
IN_AMT  in  AMT_W  total shift amount.
IN_DATA  in  DATA_W  operand.
OUT_VALID  out  1  result valid.
OUT_READY  in  1  downstream accepts result.
OUT_DATA  out  DATA_W  shifted result.
BUSY  out  1  high in SHIFT or DONE.

Behaviour:
- Reset (RST_N=0, asynchronous): state=IDLE; OUT_DATA=0; OUT_VALID=0; BUSY=0; IN_READY=1 as soon as RST_N=1. Internal dir/remaining registers clear to 0.
- States: IDLE, SHIFT, DONE. IN_READY=1 only in IDLE; OUT_VALID=1 only in DONE.
- IDLE:
  - On IN_VALID&&IN_READY at an edge: latch dir<=IN_DIR, acc<=IN_DATA, rem<=IN_AMT; go to SHIFT.
  - IN_VALID while not in IDLE is ignored; no queuing.
- SHIFT, once per cycle:
  - step = (rem>MAX_STEP) ? MAX_STEP : rem[4:0].
  - acc <= Barrel_Shifter(dir, step, acc).
  - rem <= rem-step.
  - If rem<=MAX_STEP, go to DONE this edge; otherwise stay in SHIFT.
- Pass count: amt 0..31 = 1 pass; 32..62 = 2 passes; 63 = 3 passes.
- amt=0 still takes one pass, with shift-by-0 passing data through unchanged.
- Latency: OUT_VALID rises N edges after the accepting edge, N = pass count.
- Result semantics:
  - Amt>=32 with left shift yields 0.
  - Amt>=32 with right shift yields all copies of bit 31.
  - Repeated arithmetic right shift composes exactly, so no special case is needed.
- DONE:
  - OUT_DATA=acc, held stable while OUT_READY=0 (no glitches, no change).
  - On OUT_VALID&&OUT_READY at an edge, go to IDLE.
  - IN_READY becomes 1 the following cycle. No same-cycle accept/return overlap.
- Width rules:
  - rem is AMT_W bits and never underflows, since step<=rem.
  - step is truncated to 5 bits only when <=31.
- Reset mid-SHIFT or mid-DONE aborts the command and discards the result; no OUT_VALID afterwards.

Decomposition:
- Shared package shift_pkg holds:
  - state enum {IDLE, SHIFT, DONE};
  - constants DATA_W=32, AMT_W=6, MAX_STEP=31;
  - direction constants DIR_LEFT=0, DIR_RIGHT=1.
- One sub-module: the existing Barrel_Shifter, instantiated once, combinational, driven by dir/step/acc. No other hierarchy.

Test Plan:
1. Right shift:
   - IN_DIR=1, IN_DATA=0x8000_0000, IN_AMT=4 -> OUT_VALID 1 edge after accept, OUT_DATA=0xF800_0000.
   - Same with IN_DATA=0x4000_0000 -> 0x0400_0000.
2. Left shift, single and two-pass:
   - IN_DIR=0, IN_DATA=0x0000_0001, IN_AMT=31 -> 0x8000_0000 after 1 edge.
   - IN_AMT=40 -> 0x0000_0000 after 2 edges, BUSY high throughout.
3. Three-pass sweep at amt=63 -> 3-edge latency for each:
   - IN_DIR=1, IN_DATA=0x8000_0000 -> 0xFFFF_FFFF.
   - IN_DIR=1, IN_DATA=0x4000_0000 -> 0x0000_0000.
   - Also sweep amt 0..63 for both directions against a reference model.
4. Amt=0: IN_DATA=0xDEAD_BEEF, either direction -> 0xDEAD_BEEF after 1 edge.
5. Backpressure:
   - Hold OUT_READY=0 for 5 cycles in DONE -> OUT_DATA and OUT_VALID stable, IN_READY=0, concurrent IN_VALID with IN_DATA=0x1234_5678 not accepted.
   - Raise OUT_READY -> IDLE next edge, IN_READY=1.
6. Reset mid-operation: assert RST_N=0 asynchronously during second pass of amt=50 -> immediately OUT_VALID=0, OUT_DATA=0, BUSY=0; after release IN_READY=1 and a new command completes normally.
